// File: rtl/dma_reg_pkg.sv
// Shared widths, register offsets, bit positions and FSM state type for the
// DMA register controller.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

package dma_reg_pkg;

  localparam int unsigned DMA_DATA_WIDTH = `DATA_WIDTH;
  localparam int unsigned DMA_ADDR_WIDTH = `ADDR_WIDTH;
  localparam int unsigned DMA_CNT_WIDTH  = 16;

  localparam int unsigned REG_CTRL       = 'h00;
  localparam int unsigned REG_IO_ADDR    = 'h04;
  localparam int unsigned REG_MEM_ADDR   = 'h08;
  localparam int unsigned REG_STATUS     = 'h0C;
  localparam int unsigned REG_XFER_COUNT = 'h10;
  localparam int unsigned REG_ERR_STATUS = 'h14;
  localparam int unsigned REG_INTR_EN    = 'h18;
  localparam int unsigned REG_INTR_STAT  = 'h1C;

  localparam int unsigned CTRL_START     = 0;
  localparam int unsigned CTRL_CNT_LSB   = 1;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_DONE      = 1;
  localparam int unsigned STAT_ERR       = 2;
  localparam int unsigned STAT_STATE_LSB = 4;

  localparam int unsigned ERR_ZERO       = 0;
  localparam int unsigned ERR_BUSY       = 1;
  localparam int unsigned ERR_MISALIGN   = 2;

  localparam int unsigned INTR_DONE      = 0;
  localparam int unsigned INTR_ERR       = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/dma_xfer_fsm.sv
// Transfer sequencer: latches the descriptor in LOAD, then issues one
// valid/ready beat per word with incrementing source/destination addresses.
module dma_xfer_fsm
  import dma_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DMA_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = DMA_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] cfg_src_i,
  input  logic [DATA_WIDTH-1:0] cfg_dst_i,
  input  logic [CNT_WIDTH-1:0]  cfg_count_i,
  input  logic                  xfer_ready_i,
  output state_e                state_o,
  output logic                  xfer_valid_o,
  output logic [DATA_WIDTH-1:0] xfer_src_o,
  output logic [DATA_WIDTH-1:0] xfer_dst_o,
  output logic [CNT_WIDTH-1:0]  xfer_count_o
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d, cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_LOAD;
      ST_LOAD: begin
        src_d   = cfg_src_i;
        dst_d   = cfg_dst_i;
        rem_d   = cfg_count_i;
        cnt_d   = '0;
        state_d = ST_XFER;
      end
      ST_XFER: if (xfer_ready_i) begin
        src_d = src_q + DATA_WIDTH'(4);
        dst_d = dst_q + DATA_WIDTH'(4);
        rem_d = rem_q - CNT_WIDTH'(1);
        if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
        if (rem_q == CNT_WIDTH'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o      = state_q;
  assign xfer_valid_o = (state_q == ST_XFER);
  assign xfer_src_o   = src_q;
  assign xfer_dst_o   = dst_q;
  assign xfer_count_o = cnt_q;

endmodule

// File: rtl/dma_reg_ctrl.sv
// DMA control block: register file, start/error qualification, read mux and
// interrupt generation around the dma_xfer_fsm sequencer.
module dma_reg_ctrl
  import dma_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DMA_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DMA_ADDR_WIDTH,
  parameter int unsigned CNT_WIDTH  = DMA_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  xfer_valid,
  input  logic                  xfer_ready,
  output logic [DATA_WIDTH-1:0] xfer_src,
  output logic [DATA_WIDTH-1:0] xfer_dst,
  output logic                  irq
);

  localparam int unsigned DirBit = CTRL_CNT_LSB + CNT_WIDTH;

  logic [CNT_WIDTH-1:0]  wcount_q, wcount_d;
  logic                  dir_q, dir_d;
  logic [DATA_WIDTH-1:0] io_q, io_d, mem_q, mem_d;
  logic [2:0]            err_q, err_d;
  logic [1:0]            ien_q, ien_d, ist_q, ist_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] rdata_q, rd_mux;

  logic sel_ctrl, sel_io, sel_mem, sel_stat, sel_cnt, sel_err, sel_ien, sel_ist;
  assign sel_ctrl = (addr == ADDR_WIDTH'(REG_CTRL));
  assign sel_io   = (addr == ADDR_WIDTH'(REG_IO_ADDR));
  assign sel_mem  = (addr == ADDR_WIDTH'(REG_MEM_ADDR));
  assign sel_stat = (addr == ADDR_WIDTH'(REG_STATUS));
  assign sel_cnt  = (addr == ADDR_WIDTH'(REG_XFER_COUNT));
  assign sel_err  = (addr == ADDR_WIDTH'(REG_ERR_STATUS));
  assign sel_ien  = (addr == ADDR_WIDTH'(REG_INTR_EN));
  assign sel_ist  = (addr == ADDR_WIDTH'(REG_INTR_STAT));

  state_e               state;
  logic [CNT_WIDTH-1:0] xcount;
  logic [CNT_WIDTH-1:0] new_cnt;
  logic idle, start_req, start_zero, start_misalign, start_busy, start_ok;

  // The start write carries its own w_count, so qualify against wdata.
  assign new_cnt        = wdata[CTRL_CNT_LSB +: CNT_WIDTH];
  assign idle           = (state == ST_IDLE);
  assign start_req      = wr_en && sel_ctrl && wdata[CTRL_START];
  assign start_zero     = start_req && idle && (new_cnt == '0);
  assign start_misalign = start_req && idle && !start_zero &&
                          ((io_q[1:0] | mem_q[1:0]) != 2'b00);
  assign start_busy     = start_req && !idle;
  assign start_ok       = start_req && idle && !start_zero && !start_misalign;

  always_comb begin
    wcount_d = wcount_q;
    dir_d    = dir_q;
    io_d     = io_q;
    mem_d    = mem_q;
    ien_d    = ien_q;
    err_d    = err_q;
    ist_d    = ist_q;
    done_d   = done_q;
    if (wr_en) begin
      if (sel_ctrl) begin
        wcount_d = new_cnt;
        dir_d    = wdata[DirBit];
      end
      if (sel_io)  io_d  = wdata;
      if (sel_mem) mem_d = wdata;
      if (sel_ien) ien_d = wdata[1:0];
      if (sel_err) err_d = err_q & ~wdata[2:0];
      if (sel_ist) ist_d = ist_q & ~wdata[1:0];
    end
    // Hardware sets follow the W1C masking so a coincident set survives.
    if (start_zero)     err_d[ERR_ZERO]     = 1'b1;
    if (start_busy)     err_d[ERR_BUSY]     = 1'b1;
    if (start_misalign) err_d[ERR_MISALIGN] = 1'b1;
    if (start_zero || start_busy || start_misalign) ist_d[INTR_ERR] = 1'b1;
    if (state == ST_LOAD) done_d = 1'b0;
    if (state == ST_DONE) begin
      done_d           = 1'b1;
      ist_d[INTR_DONE] = 1'b1;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (sel_ctrl) begin
      rd_mux[CTRL_CNT_LSB +: CNT_WIDTH] = wcount_q;
      rd_mux[DirBit]                    = dir_q;
    end else if (sel_io)   rd_mux = io_q;
    else if (sel_mem)      rd_mux = mem_q;
    else if (sel_stat) begin
      rd_mux[STAT_BUSY]           = (state == ST_LOAD) || (state == ST_XFER);
      rd_mux[STAT_DONE]           = done_q;
      rd_mux[STAT_ERR]            = |err_q;
      rd_mux[STAT_STATE_LSB +: 2] = state;
    end else if (sel_cnt)  rd_mux[CNT_WIDTH-1:0] = xcount;
    else if (sel_err)      rd_mux[2:0] = err_q;
    else if (sel_ien)      rd_mux[1:0] = ien_q;
    else if (sel_ist)      rd_mux[1:0] = ist_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcount_q <= '0;
      dir_q    <= 1'b0;
      io_q     <= '0;
      mem_q    <= '0;
      ien_q    <= '0;
      err_q    <= '0;
      ist_q    <= '0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wcount_q <= wcount_d;
      dir_q    <= dir_d;
      io_q     <= io_d;
      mem_q    <= mem_d;
      ien_q    <= ien_d;
      err_q    <= err_d;
      ist_q    <= ist_d;
      done_q   <= done_d;
      if (rd_en) rdata_q <= rd_mux;
    end
  end

  dma_xfer_fsm #(
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_fsm (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_ok),
    .cfg_src_i    (dir_q ? mem_q : io_q),
    .cfg_dst_i    (dir_q ? io_q : mem_q),
    .cfg_count_i  (wcount_q),
    .xfer_ready_i (xfer_ready),
    .state_o      (state),
    .xfer_valid_o (xfer_valid),
    .xfer_src_o   (xfer_src),
    .xfer_dst_o   (xfer_dst),
    .xfer_count_o (xcount)
  );

  assign rdata = rdata_q;
  assign irq   = |(ist_q & ien_q);

endmodule

// File: tb/tb_dma_reg_ctrl.sv
// Self-checking bench for dma_reg_ctrl: register vectors, directed transfer
// corner cases and randomized transfers against a descriptor-level model.
module tb_dma_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        xfer_valid, xfer_ready, irq;
  logic [31:0] xfer_src, xfer_dst;

  int unsigned checks = 0, errors = 0;

  logic [31:0]  got_src[$], got_dst[$];
  int unsigned  got_cyc[$];
  int unsigned  cyc = 0;
  bit           rdy_hold = 1'b0, rdy_rand = 1'b0;
  bit           rdy_pat[$];

  dma_reg_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .xfer_valid(xfer_valid),
    .xfer_ready(xfer_ready), .xfer_src(xfer_src), .xfer_dst(xfer_dst),
    .irq(irq)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Ready driver: changes 2 time units after each rising edge.
  initial begin
    xfer_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (rdy_pat.size() != 0) xfer_ready = rdy_pat.pop_front();
      else if (rdy_rand)       xfer_ready = 1'($urandom_range(0, 1));
      else                     xfer_ready = rdy_hold;
    end
  end

  // Beat monitor: samples 1 time unit before each rising edge.
  initial begin
    bit pv, pr;
    logic [31:0] ps, pd;
    pv = 0; pr = 0; ps = '0; pd = '0;
    forever begin
      @(negedge clk); #4;
      cyc++;
      if (rst) begin
        pv = 0;
        continue;
      end
      if (pv && !pr) begin
        check("hold_valid", 32'(xfer_valid), 32'd1);
        check("hold_src", xfer_src, ps);
        check("hold_dst", xfer_dst, pd);
      end
      if (xfer_valid && xfer_ready) begin
        got_src.push_back(xfer_src);
        got_dst.push_back(xfer_dst);
        got_cyc.push_back(cyc);
      end
      pv = xfer_valid; pr = xfer_ready; ps = xfer_src; pd = xfer_dst;
    end
  end

  task automatic tick(int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(logic [7:0] a, logic [31:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic rd(logic [7:0] a, output logic [31:0] d);
    addr = a; rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    d = rdata;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    tick(2);
    rst = 1'b0;
    got_src.delete(); got_dst.delete(); got_cyc.delete();
  endtask

  task automatic clear_beats();
    got_src.delete(); got_dst.delete(); got_cyc.delete();
  endtask

  task automatic wait_done(string tag);
    logic [31:0] s;
    bit ok = 0;
    for (int unsigned k = 0; k < 200; k++) begin
      rd(8'h0C, s);
      if (s[1:0] == 2'b10) begin ok = 1; break; end
    end
    check({tag, "_done_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_valid(string tag);
    int unsigned k = 0;
    while (!xfer_valid && k < 20) begin tick(1); k++; end
    check({tag, "_valid_seen"}, 32'(xfer_valid), 32'd1);
  endtask

  task automatic cmp_beats(string tag, logic [31:0] s0, logic [31:0] d0,
                           int unsigned n, bit back2back);
    check({tag, "_nbeats"}, 32'(got_src.size()), 32'(n));
    for (int unsigned i = 0; i < n && i < got_src.size(); i++) begin
      check($sformatf("%s_src%0d", tag, i), got_src[i], s0 + 32'(4 * i));
      check($sformatf("%s_dst%0d", tag, i), got_dst[i], d0 + 32'(4 * i));
    end
    if (back2back && n > 0 && got_cyc.size() == n)
      check({tag, "_span"}, 32'(got_cyc[n-1] - got_cyc[0]), 32'(n - 1));
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_FFF8;
      1:       return r;
      default: return r & ~32'h3;
    endcase
  endfunction

  typedef struct {
    bit          wr;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t        vecs[$];
    logic [31:0] d;
    logic [31:0] m_err, m_ist, m_cnt;
    bit          m_done;

    vecs.push_back('{0, 8'h00, 32'h0, 32'h0});
    vecs.push_back('{0, 8'h04, 32'h0, 32'h0});
    vecs.push_back('{0, 8'h08, 32'h0, 32'h0});
    vecs.push_back('{0, 8'h0C, 32'h0, 32'h0});
    vecs.push_back('{0, 8'h10, 32'h0, 32'h0});
    vecs.push_back('{0, 8'h14, 32'h0, 32'h0});
    vecs.push_back('{0, 8'h18, 32'h0, 32'h0});
    vecs.push_back('{0, 8'h1C, 32'h0, 32'h0});
    vecs.push_back('{0, 8'h20, 32'h0, 32'h0});
    vecs.push_back('{1, 8'h04, 32'hDEADBEEF, 32'hDEADBEEF});
    vecs.push_back('{1, 8'h08, 32'h12345678, 32'h12345678});
    vecs.push_back('{1, 8'h00, 32'hFFFFFFFE, 32'h0003FFFE});
    vecs.push_back('{1, 8'h18, 32'hFFFFFFFF, 32'h00000003});
    vecs.push_back('{1, 8'h0C, 32'hFFFFFFFF, 32'h0});
    vecs.push_back('{1, 8'h10, 32'hFFFFFFFF, 32'h0});
    vecs.push_back('{1, 8'h14, 32'h7, 32'h0});
    vecs.push_back('{1, 8'h1C, 32'h3, 32'h0});
    vecs.push_back('{1, 8'h24, 32'hFFFFFFFF, 32'h0});

    tick(1);
    do_reset();
    check("rst_rdata", rdata, 32'h0);
    check("rst_valid", 32'(xfer_valid), 32'h0);
    check("rst_src", xfer_src, 32'h0);
    check("rst_dst", xfer_dst, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    foreach (vecs[i]) begin
      if (vecs[i].wr) wr(vecs[i].a, vecs[i].wd);
      rd(vecs[i].a, d);
      check($sformatf("vec%0d_a%02h", i, vecs[i].a), d, vecs[i].exp);
    end
    check("vec_irq", 32'(irq), 32'h0);

    // Read and write same address in one cycle; rdata then holds.
    wr(8'h04, 32'h40);
    addr = 8'h04; wdata = 32'h80; wr_en = 1'b1; rd_en = 1'b1;
    tick(1);
    wr_en = 1'b0; rd_en = 1'b0;
    check("rdwr_old", rdata, 32'h40);
    tick(2);
    check("rdata_hold", rdata, 32'h40);
    rd(8'h04, d);
    check("rdwr_new", d, 32'h80);

    // Basic IO->MEM transfer.
    do_reset();
    rdy_hold = 1'b1;
    wr(8'h04, 32'h100); wr(8'h08, 32'h200); wr(8'h18, 32'h1);
    clear_beats();
    wr(8'h00, (32'd4 << 1) | 32'd1);
    wait_done("basic");
    cmp_beats("basic", 32'h100, 32'h200, 4, 1);
    rd(8'h10, d); check("basic_xcount", d, 32'd4);
    rd(8'h0C, d); check("basic_status", d, 32'h2);
    check("basic_irq", 32'(irq), 32'd1);
    wr(8'h1C, 32'h1);
    check("w1c_irq_low", 32'(irq), 32'd0);
    rd(8'h1C, d); check("w1c_ist", d, 32'h0);

    // Backpressure, MEM->IO.
    do_reset();
    rdy_hold = 1'b0;
    wr(8'h04, 32'hA00); wr(8'h08, 32'hB00);
    clear_beats();
    wr(8'h00, (32'd1 << 17) | (32'd3 << 1) | 32'd1);
    wait_valid("bp");
    rdy_pat.push_back(1); rdy_pat.push_back(0);
    rdy_pat.push_back(0); rdy_pat.push_back(1);
    rdy_hold = 1'b1;
    wait_done("bp");
    cmp_beats("bp", 32'hB00, 32'hA00, 3, 0);

    // Zero count.
    do_reset();
    wr(8'h00, 32'h1);
    tick(4);
    check("zero_valid", 32'(xfer_valid), 32'd0);
    check("zero_nbeats", 32'(got_src.size()), 32'd0);
    rd(8'h14, d); check("zero_err", d, 32'h1);

    // Misaligned IO address.
    do_reset();
    wr(8'h04, 32'h102); wr(8'h08, 32'h200);
    wr(8'h00, (32'd4 << 1) | 32'd1);
    tick(4);
    check("mis_nbeats", 32'(got_src.size()), 32'd0);
    rd(8'h14, d); check("mis_err", d, 32'h4);
    rd(8'h0C, d); check("mis_status", d, 32'h4);

    // Second start while transferring; new CTRL value must not leak in.
    do_reset();
    rdy_hold = 1'b0;
    wr(8'h04, 32'h300); wr(8'h08, 32'h400); wr(8'h18, 32'h2);
    clear_beats();
    wr(8'h00, (32'd4 << 1) | 32'd1);
    wait_valid("busy");
    wr(8'h00, (32'd2 << 1) | 32'd1);
    rdy_hold = 1'b1;
    wait_done("busy");
    cmp_beats("busy", 32'h300, 32'h400, 4, 1);
    rd(8'h14, d); check("busy_err", d, 32'h2);
    rd(8'h10, d); check("busy_xcount", d, 32'd4);
    rd(8'h00, d); check("busy_ctrl", d, 32'd2 << 1);
    rd(8'h1C, d); check("busy_ist", d, 32'h3);
    check("busy_irq", 32'(irq), 32'd1);

    // W1C of INTR_STATUS.done in the same cycle the done is raised.
    do_reset();
    rdy_hold = 1'b1;
    wr(8'h04, 32'h10); wr(8'h08, 32'h20); wr(8'h18, 32'h1);
    wr(8'h00, (32'd1 << 1) | 32'd1);
    wait_valid("race");
    tick(1);
    wr(8'h1C, 32'h1);
    rd(8'h1C, d); check("race_ist", d, 32'h1);
    check("race_irq", 32'(irq), 32'd1);

    // Reset in the middle of a transfer.
    do_reset();
    rdy_hold = 1'b1;
    wr(8'h04, 32'h500); wr(8'h08, 32'h600); wr(8'h18, 32'h3);
    clear_beats();
    wr(8'h00, (32'd8 << 1) | 32'd1);
    for (int k = 0; k < 30 && got_src.size() < 3; k++) tick(1);
    check("mid_reached3", 32'(got_src.size() >= 3), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_valid", 32'(xfer_valid), 32'd0);
    rd(8'h0C, d); check("mid_status", d, 32'h0);
    rd(8'h10, d); check("mid_xcount", d, 32'h0);
    rd(8'h1C, d); check("mid_ist", d, 32'h0);
    check("mid_irq", 32'(irq), 32'd0);
    tick(3);
    check("mid_valid_later", 32'(xfer_valid), 32'd0);

    // Randomized descriptors against the model.
    do_reset();
    rdy_rand = 1'b1;
    m_err = 0; m_ist = 0; m_cnt = 0; m_done = 0;
    for (int it = 0; it < 30; it++) begin
      logic [31:0] io, mem, emask, imask, ien;
      int unsigned cnt;
      bit dir;
      io    = rand_addr();
      mem   = rand_addr();
      cnt   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
      dir   = 1'($urandom_range(0, 1));
      ien   = 32'($urandom_range(0, 3));
      emask = 32'($urandom_range(0, 7));
      imask = 32'($urandom_range(0, 3));
      wr(8'h04, io); wr(8'h08, mem); wr(8'h18, ien);
      wr(8'h14, emask); wr(8'h1C, imask);
      m_err &= ~emask;
      m_ist &= ~imask;
      clear_beats();
      wr(8'h00, (32'(dir) << 17) | (32'(cnt) << 1) | 32'd1);
      if (cnt == 0) begin
        m_err |= 32'h1; m_ist |= 32'h2;
        tick(4);
        check($sformatf("rnd%0d_nbeats", it), 32'(got_src.size()), 32'd0);
      end else if (((io | mem) & 32'h3) != 0) begin
        m_err |= 32'h4; m_ist |= 32'h2;
        tick(4);
        check($sformatf("rnd%0d_nbeats", it), 32'(got_src.size()), 32'd0);
      end else begin
        wait_done($sformatf("rnd%0d", it));
        cmp_beats($sformatf("rnd%0d", it), dir ? mem : io, dir ? io : mem, cnt, 0);
        m_cnt = 32'(cnt); m_done = 1; m_ist |= 32'h1;
      end
      rd(8'h14, d); check($sformatf("rnd%0d_err", it), d, m_err);
      rd(8'h1C, d); check($sformatf("rnd%0d_ist", it), d, m_ist);
      rd(8'h10, d); check($sformatf("rnd%0d_xcount", it), d, m_cnt);
      rd(8'h0C, d);
      check($sformatf("rnd%0d_status", it), d,
            (32'(m_err != 0) << 2) | (32'(m_done) << 1));
      check($sformatf("rnd%0d_irq", it), 32'(irq), 32'((m_ist & ien) != 0));
    end
    rdy_rand = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
